// File: rtl/regfile_sb.sv
// Integer register file with same-cycle write bypass, hardwired x0 and a
// per-register busy scoreboard so decode can spot reads of in-flight results.

module regfile_sb_rdport #(
  parameter int REG_WIDTH = 32,
  parameter int NAME_BITS = 5,
  parameter int DEPTH     = 1 << NAME_BITS
) (
  input  logic [NAME_BITS-1:0]              rs,
  input  logic [DEPTH-1:0][REG_WIDTH-1:0]   regs,
  input  logic [DEPTH-1:0]                  busy,
  input  logic                              we,
  input  logic [NAME_BITS-1:0]              ws,
  input  logic [REG_WIDTH-1:0]              wd,
  output logic [REG_WIDTH-1:0]              rd,
  output logic                              rd_busy
);

  logic hit;

  assign hit = we && (ws == rs);

  // A same-cycle writeback both supplies the data and retires the hazard.
  always_comb begin
    rd      = '0;
    rd_busy = 1'b0;
    if (rs != '0) begin
      rd      = hit ? wd : regs[rs];
      rd_busy = busy[rs] & ~hit;
    end
  end

endmodule

module regfile_sb #(
  parameter int REG_WIDTH = 32,
  parameter int NAME_BITS = 5,
  parameter int NUM_READ  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*NAME_BITS-1:0]  rs,
  output logic [NUM_READ*REG_WIDTH-1:0]  rd,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           we,
  input  logic [NAME_BITS-1:0]           ws,
  input  logic [REG_WIDTH-1:0]           wd,
  input  logic                           claim_en,
  input  logic [NAME_BITS-1:0]           claim_rd,
  output logic [(1<<NAME_BITS)-1:0]      busy_vec
);

  localparam int DEPTH = 1 << NAME_BITS;

  typedef struct packed {
    logic                 en;
    logic [NAME_BITS-1:0] idx;
    logic [REG_WIDTH-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                 en;
    logic [NAME_BITS-1:0] idx;
  } claim_req_t;

  wb_req_t                        wb;
  claim_req_t                     cl;
  logic [DEPTH-1:0][REG_WIDTH-1:0] regs;
  logic [DEPTH-1:0]               busy;

  assign wb = '{en: we, idx: ws, data: wd};
  assign cl = '{en: claim_en, idx: claim_rd};

  // x0 has no storage; it is a constant zero on both data and busy.
  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_reg
    logic                 wr_hit, cl_hit;
    logic [REG_WIDTH-1:0] q;
    logic                 b;

    assign wr_hit = wb.en && (wb.idx == NAME_BITS'(k));
    assign cl_hit = cl.en && (cl.idx == NAME_BITS'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (wr_hit) q <= wb.data;
    end

    // Claim takes priority: a new producer owns the register even if the
    // previous one retires on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      b <= 1'b0;
      else if (cl_hit) b <= 1'b1;
      else if (wr_hit) b <= 1'b0;
    end

    assign regs[k] = q;
    assign busy[k] = b;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_sb_rdport #(
      .REG_WIDTH (REG_WIDTH),
      .NAME_BITS (NAME_BITS),
      .DEPTH     (DEPTH)
    ) u_port (
      .rs      (rs[i*NAME_BITS +: NAME_BITS]),
      .regs    (regs),
      .busy    (busy),
      .we      (wb.en),
      .ws      (wb.idx),
      .wd      (wb.data),
      .rd      (rd[i*REG_WIDTH +: REG_WIDTH]),
      .rd_busy (rd_busy[i])
    );
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 2-port instance plus a 4-port,
// 16-entry, 16-bit instance for the wide-read scenario.

module tb_regfile_sb;

  logic        clk;
  logic        rst_n;

  logic [9:0]  rs;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  ws;
  logic [31:0] wd;
  logic        claim_en;
  logic [4:0]  claim_rd;
  logic [31:0] busy_vec;

  logic [15:0] rs4;
  logic [63:0] rd4;
  logic [3:0]  rd_busy4;
  logic        we4;
  logic [3:0]  ws4;
  logic [15:0] wd4;
  logic        claim_en4;
  logic [3:0]  claim_rd4;
  logic [15:0] busy_vec4;

  int tests = 0;
  int fails = 0;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rd(rd), .rd_busy(rd_busy),
    .we(we), .ws(ws), .wd(wd), .claim_en(claim_en), .claim_rd(claim_rd),
    .busy_vec(busy_vec)
  );

  regfile_sb #(.REG_WIDTH(16), .NAME_BITS(4), .NUM_READ(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rs(rs4), .rd(rd4), .rd_busy(rd_busy4),
    .we(we4), .ws(ws4), .wd(wd4), .claim_en(claim_en4), .claim_rd(claim_rd4),
    .busy_vec(busy_vec4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks happen #1 later, well away
  // from the rising edge.
  task automatic idle();
    we = 1'b0; ws = '0; wd = '0; claim_en = 1'b0; claim_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Values right out of the initial reset
    #1;
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_busy_vec got %h exp %h", busy_vec, 32'h0); end
    tests++;
    if (rd !== 64'h0) begin fails++; $display("FAIL reset_rd got %h exp %h", rd, 64'h0); end
    // Write x5 and claim x6, then reset between edges
    idle(); we = 1'b1; ws = 5'd5; wd = 32'hDEADBEEF; claim_en = 1'b1; claim_rd = 5'd6;
    step();
    idle(); rs = {5'd6, 5'd5};
    #1;
    tests++;
    if (rd[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_reset_x5 got %h exp %h", rd[31:0], 32'hDEADBEEF); end
    tests++;
    if (busy_vec !== 32'h0000_0040) begin fails++; $display("FAIL pre_reset_busy got %h exp %h", busy_vec, 32'h40); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (rd[31:0] !== 32'h0) begin fails++; $display("FAIL async_reset_x5 got %h exp %h", rd[31:0], 32'h0); end
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL async_reset_busy got %h exp %h", busy_vec, 32'h0); end
    tests++;
    if (rd_busy !== 2'b00) begin fails++; $display("FAIL async_reset_rd_busy got %b exp %b", rd_busy, 2'b00); end
    // Writes and claims presented while reset is held are discarded
    we = 1'b1; ws = 5'd4; wd = 32'h0BAD_F00D; claim_en = 1'b1; claim_rd = 5'd4;
    step();
    idle(); rst_n = 1'b1; rs = {5'd5, 5'd4};
    #1;
    tests++;
    if (rd !== 64'h0) begin fails++; $display("FAIL reset_hold_rd got %h exp %h", rd, 64'h0); end
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_hold_busy got %h exp %h", busy_vec, 32'h0); end
  endtask

  task automatic test_write_bypass();
    idle(); we = 1'b1; ws = 5'd3; wd = 32'h1234; rs = {5'd0, 5'd3};
    #1;
    tests++;
    if (rd[31:0] !== 32'h1234) begin fails++; $display("FAIL bypass_rd0 got %h exp %h", rd[31:0], 32'h1234); end
    step();
    idle(); rs = {5'd3, 5'd3};
    #1;
    tests++;
    if (rd !== {32'h1234, 32'h1234}) begin fails++; $display("FAIL storage_x3 got %h exp %h", rd, {32'h1234, 32'h1234}); end
    // x0 write is dropped, both in bypass and in storage
    we = 1'b1; ws = 5'd0; wd = 32'd5; rs = {5'd0, 5'd3};
    #1;
    tests++;
    if (rd[63:32] !== 32'h0) begin fails++; $display("FAIL x0_bypass got %h exp %h", rd[63:32], 32'h0); end
    step();
    idle(); rs = {5'd0, 5'd0};
    #1;
    tests++;
    if (rd !== 64'h0) begin fails++; $display("FAIL x0_storage got %h exp %h", rd, 64'h0); end
  endtask

  task automatic test_scoreboard();
    idle(); claim_en = 1'b1; claim_rd = 5'd7; rs = {5'd0, 5'd7};
    #1;
    tests++;
    if (rd_busy !== 2'b00) begin fails++; $display("FAIL claim_same_cycle got %b exp %b", rd_busy, 2'b00); end
    step();
    idle();
    #1;
    tests++;
    if (busy_vec !== 32'h0000_0080) begin fails++; $display("FAIL claim_busy_vec got %h exp %h", busy_vec, 32'h80); end
    tests++;
    if (rd_busy !== 2'b01) begin fails++; $display("FAIL claim_rd_busy got %b exp %b", rd_busy, 2'b01); end
    we = 1'b1; ws = 5'd7; wd = 32'hA5;
    #1;
    tests++;
    if (rd_busy !== 2'b00) begin fails++; $display("FAIL wb_mask_rd_busy got %b exp %b", rd_busy, 2'b00); end
    tests++;
    if (rd[31:0] !== 32'hA5) begin fails++; $display("FAIL wb_bypass got %h exp %h", rd[31:0], 32'hA5); end
    tests++;
    if (busy_vec !== 32'h0000_0080) begin fails++; $display("FAIL wb_raw_busy got %h exp %h", busy_vec, 32'h80); end
    step();
    idle();
    #1;
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL wb_clear got %h exp %h", busy_vec, 32'h0); end
    tests++;
    if (rd[31:0] !== 32'hA5) begin fails++; $display("FAIL wb_storage got %h exp %h", rd[31:0], 32'hA5); end
  endtask

  task automatic test_collision();
    idle(); claim_en = 1'b1; claim_rd = 5'd9;
    step();
    idle(); claim_en = 1'b1; claim_rd = 5'd9; we = 1'b1; ws = 5'd9; wd = 32'h99;
    step();
    idle(); rs = {5'd0, 5'd9};
    #1;
    tests++;
    if (busy_vec !== 32'h0000_0200) begin fails++; $display("FAIL collide_busy got %h exp %h", busy_vec, 32'h200); end
    tests++;
    if (rd[31:0] !== 32'h99) begin fails++; $display("FAIL collide_data got %h exp %h", rd[31:0], 32'h99); end
    tests++;
    if (rd_busy !== 2'b01) begin fails++; $display("FAIL collide_rd_busy got %b exp %b", rd_busy, 2'b01); end
    // Re-claim of a busy register; a single writeback still retires it
    claim_en = 1'b1; claim_rd = 5'd9;
    step();
    idle(); we = 1'b1; ws = 5'd9; wd = 32'h77;
    step();
    idle();
    #1;
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL reclaim_clear got %h exp %h", busy_vec, 32'h0); end
    // Writeback to a non-busy register: data lands, busy stays clear
    we = 1'b1; ws = 5'd12; wd = 32'hC0FFEE;
    step();
    idle(); rs = {5'd12, 5'd9};
    #1;
    tests++;
    if (rd !== {32'hC0FFEE, 32'h77} || busy_vec !== 32'h0) begin
      fails++; $display("FAIL idle_wb got rd %h busy %h exp rd %h busy %h", rd, busy_vec, {32'hC0FFEE, 32'h77}, 32'h0);
    end
  endtask

  task automatic test_x0_claim();
    idle(); claim_en = 1'b1; claim_rd = 5'd0; rs = {5'd0, 5'd0};
    step();
    idle();
    #1;
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL x0_claim_busy got %h exp %h", busy_vec, 32'h0); end
    tests++;
    if (rd_busy !== 2'b00) begin fails++; $display("FAIL x0_claim_rd_busy got %b exp %b", rd_busy, 2'b00); end
  endtask

  task automatic test_wide_ports();
    logic [15:0] exp [16];
    logic [3:0]  sel [8][4];
    exp[0] = 16'h0;
    for (int k = 1; k < 16; k++) exp[k] = 16'((k << 12) | (k << 4) | 16'h0A05);
    sel[0] = '{4'd1, 4'd2, 4'd3, 4'd4};
    sel[1] = '{4'd5, 4'd6, 4'd7, 4'd8};
    sel[2] = '{4'd9, 4'd10, 4'd11, 4'd12};
    sel[3] = '{4'd13, 4'd14, 4'd15, 4'd0};
    sel[4] = '{4'd15, 4'd1, 4'd8, 4'd3};
    sel[5] = '{4'd7, 4'd7, 4'd2, 4'd14};
    sel[6] = '{4'd0, 4'd11, 4'd0, 4'd6};
    sel[7] = '{4'd12, 4'd13, 4'd9, 4'd5};
    for (int k = 1; k < 16; k++) begin
      we4 = 1'b1; ws4 = 4'(k); wd4 = exp[k];
      step();
    end
    we4 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int p = 0; p < 4; p++) rs4[p*4 +: 4] = sel[v][p];
      #1;
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (rd4[p*16 +: 16] !== exp[sel[v][p]]) begin
          fails++; $display("FAIL wide_v%0d_p%0d got %h exp %h", v, p, rd4[p*16 +: 16], exp[sel[v][p]]);
        end
      end
      step();
    end
    tests++;
    if (busy_vec4 !== 16'h0 || rd_busy4 !== 4'h0) begin
      fails++; $display("FAIL wide_busy got %h/%b exp 0/0", busy_vec4, rd_busy4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(); rs = '0;
    rs4 = '0; we4 = 1'b0; ws4 = '0; wd4 = '0; claim_en4 = 1'b0; claim_rd4 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_collision();
    test_x0_claim();
    test_wide_ports();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Clocked, parametrised integer register file with an integrated write-tracking scoreboard for the RISC-V core's decode/writeback stages. It provides NUM_READ combinational read ports with same-cycle write bypass, a hardwired-zero register 0, and one synchronous write port. It also keeps a per-register busy bit, so decode can detect reads of registers whose producer has not yet written back.

## Interface
Parameters:
- REG_WIDTH, 32, data width of each register
- NAME_BITS, 5, register index width; depth = 2^NAME_BITS
- NUM_READ, 2, number of read ports (legal 1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs  in  NUM_READ*NAME_BITS  read indices; port i uses bits [i*NAME_BITS +: NAME_BITS]
- rd  out  NUM_READ*REG_WIDTH  read data; port i uses bits [i*REG_WIDTH +: REG_WIDTH]
- rd_busy  out  NUM_READ  port i reads a register with an outstanding producer
- we  in  1  writeback enable
- ws  in  NAME_BITS  writeback register index
- wd  in  REG_WIDTH  writeback data
- claim_en  in  1  decode issues an instruction that will write claim_rd
- claim_rd  in  NAME_BITS  destination register being claimed
- busy_vec  out  2^NAME_BITS  raw scoreboard bits, bit k = register k busy

## Operation
- Storage: 2^NAME_BITS × REG_WIDTH flops. Register 0 is never written and always reads 0.
- Write: at the rising clk edge, if we=1 and ws!=0, regs[ws] <= wd. A write with ws=0 is ignored.
- Read port i (combinational):
  - rs_i==0 -> 0
  - else we=1 and ws==rs_i -> wd (bypass)
  - else regs[rs_i]
- Scoreboard: one busy bit per register; busy[0] is constant 0.
  - At the edge, we=1 with ws!=0 clears busy[ws].
  - At the edge, claim_en=1 with claim_rd!=0 sets busy[claim_rd].
  - Same register claimed and written back in the same cycle: the claim wins and busy stays 1, because a new producer now owns it.
  - Claiming an already-busy register leaves it busy. Only the latest producer is tracked, with no count.
  - A writeback to a non-busy register is legal. The data is written and busy stays 0.
- rd_busy[i] = busy[rs_i] & ~(we & ws==rs_i). A same-cycle writeback resolves the hazard through the bypass. rd_busy[i] is 0 when rs_i==0.
- busy_vec exposes the registered busy bits directly, without bypass masking.
- All read-side outputs are purely combinational from inputs and state, with no clocked output registers.

## Timing
- Reset (rst_n=0, asynchronous): all registers = 0 and all busy bits = 0 immediately. rd therefore reads 0 on every port, rd_busy = 0 and busy_vec = 0.
  - State is held while rst_n=0, and we/claim_en are ignored.
  - Deassertion is synchronised externally. The first update occurs on the first rising edge with rst_n=1.
- Write latency: data is visible at rd via the bypass in the same cycle as we. It is visible from storage in the cycle after the edge.
- Claim latency: busy is visible on rd_busy and busy_vec in the cycle after the claim edge. There is no same-cycle claim-to-read forwarding; decode owns intra-bundle hazards.
- Reset asserted mid-operation discards pending writes and claims on that edge. The async clear dominates.
- Read paths must meet one cycle from rs/we/ws/wd to rd.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst_n low asynchronously between edges -> rd reads 0 for rs=5 immediately, and busy_vec=0.
- Write/read/bypass:
  - we=1, ws=3, wd=0x1234, rs0=3 -> rd0=0x1234 in the same cycle via bypass.
  - Next cycle, we=0 -> rd0=0x1234 from storage.
  - we=1, ws=0, wd=5, rs1=0 -> rd1=0, and x0 remains 0 afterwards.
- Scoreboard basic:
  - claim_en=1, claim_rd=7 -> next cycle busy_vec[7]=1, and rd_busy0=1 for rs0=7.
  - Writeback ws=7, wd=0xA5 -> rd_busy0=0 and rd0=0xA5 in that cycle; busy_vec[7]=0 the following cycle.
- Claim/writeback collision: x9 busy, then claim_en=1, claim_rd=9 and we=1, ws=9 in the same cycle -> regs[9] updated and busy_vec[9] stays 1.
- x0 claim: claim_en=1, claim_rd=0 -> busy_vec all 0, rd_busy=0 for rs=0.
- Parameter sweep: NUM_READ=4, NAME_BITS=4, REG_WIDTH=16; write distinct values to x1..x15 and read them on all 4 ports simultaneously -> each port returns its own register, with no cross-port aliasing.
